// File: rtl/baby_vga_pkg.sv
// baby_vga shared constants and types.
// Used by the line store and its read sequencer.
package baby_vga_pkg;

  localparam int FB_ROWS = 16;
  localparam int FB_COLS = 32;
  localparam int FB_ADDR_W = 4;
  localparam int FB_READ_LAT_DEFAULT = 8;

  typedef enum logic [0:0] {
    RD_IDLE,
    RD_WAIT
  } read_state_t;

endpackage

// File: rtl/baby_vga_read_seq.sv
// Fixed-latency read sequencer for the baby VGA line store.
// Emits capture on the cycle the row word is sampled into r_data.
module baby_vga_read_seq
  import baby_vga_pkg::*;
#(
  parameter int READ_LAT = FB_READ_LAT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r_req,
  input  logic [FB_ADDR_W-1:0] r_addr,
  output logic                 r_busy,
  output logic                 r_ready,
  output logic                 capture,
  output logic [FB_ADDR_W-1:0] cap_addr
);

  read_state_t state;
  logic [3:0]  cnt;

  assign capture = (state == RD_WAIT) &&
                   (cnt == 4'(READ_LAT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RD_IDLE;
      cnt      <= '0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      cap_addr <= '0;
    end else begin
      r_ready <= capture;
      case (state)
        RD_IDLE: begin
          // the cycle r_ready is high is still closed to new requests
          if (r_req && !r_ready) begin
            cap_addr <= r_addr;
            cnt      <= 4'd1;
            r_busy   <= 1'b1;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (capture) begin
            cnt    <= '0;
            r_busy <= 1'b0;
            state  <= RD_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/baby_vga_line_store.sv
// 16x32 monochrome bitmap store with read port and pixel output.
// BABY_VGA_LINE_SHADOW_EN adds a per-scanline shadow row.
module baby_vga_line_store
  import baby_vga_pkg::*;
#(
  parameter int ROWS     = FB_ROWS,
  parameter int READ_LAT = FB_READ_LAT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_en,
  input  logic [FB_ADDR_W-1:0] w_addr,
  input  logic [FB_COLS-1:0]   w_data,
  input  logic                 r_req,
  input  logic [FB_ADDR_W-1:0] r_addr,
  output logic [FB_COLS-1:0]   r_data,
  output logic                 r_ready,
  output logic                 r_busy,
  input  logic                 line_start,
  input  logic [FB_ADDR_W-1:0] disp_row,
  input  logic [4:0]           disp_col,
  input  logic                 disp_blank,
  output logic                 pixel
);

  logic [FB_COLS-1:0]   rows [ROWS];
  logic [FB_COLS-1:0]   disp_word;
  logic                 capture;
  logic [FB_ADDR_W-1:0] cap_addr;

  baby_vga_read_seq #(
    .READ_LAT(READ_LAT)
  ) u_read_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .r_req   (r_req),
    .r_addr  (r_addr),
    .r_busy  (r_busy),
    .r_ready (r_ready),
    .capture (capture),
    .cap_addr(cap_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) rows[i] <= '0;
    end else if (w_en) begin
      rows[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_data <= '0;
    else if (capture) r_data <= rows[cap_addr];
  end

`ifdef BABY_VGA_LINE_SHADOW_EN
  logic [FB_COLS-1:0] shadow;

  // same-cycle write to the captured row wins over the stored word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (line_start) begin
      if (w_en && (w_addr == disp_row)) shadow <= w_data;
      else shadow <= rows[disp_row];
    end
  end

  assign disp_word = shadow;
`else
  logic unused_line_start;

  assign unused_line_start = line_start;
  assign disp_word = rows[disp_row];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) pixel <= 1'b0;
    else if (disp_blank) pixel <= 1'b0;
    else pixel <= disp_word[disp_col];
  end

endmodule

// File: tb/tb_baby_vga_line_store.sv
// Scoreboard bench for baby_vga_line_store.
// Reference model tracks the bitmap, display state and read queue.
module tb_baby_vga_line_store;
  import baby_vga_pkg::*;

  localparam int LAT = 8;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        w_en;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic        r_req;
  logic [3:0]  r_addr;
  logic [31:0] r_data;
  logic        r_ready;
  logic        r_busy;
  logic        line_start;
  logic [3:0]  disp_row;
  logic [4:0]  disp_col;
  logic        disp_blank;
  logic        pixel;

  baby_vga_line_store #(
    .ROWS(16),
    .READ_LAT(LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .r_req     (r_req),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .r_ready   (r_ready),
    .r_busy    (r_busy),
    .line_start(line_start),
    .disp_row  (disp_row),
    .disp_col  (disp_col),
    .disp_blank(disp_blank),
    .pixel     (pixel)
  );

  typedef struct {
    logic [3:0]  addr;
    int          due;
    logic [31:0] data;
  } rd_t;

  rd_t         sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] mem[16];
  logic [31:0] snap[16];
  logic [31:0] shadow_m;
  logic        pix_m;
  logic [31:0] rdata_m;
  bit          pend_m;
  bit          done_last;
  bit          done_now;
  rd_t         t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // reference model: one step per clock edge, from the rules of the block
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      foreach (mem[i]) mem[i] = '0;
      shadow_m  = '0;
      pix_m     = 1'b0;
      rdata_m   = '0;
      pend_m    = 1'b0;
      done_last = 1'b0;
      sb.delete();
    end else begin
      snap = mem;
      done_now = 1'b0;
`ifdef BABY_VGA_LINE_SHADOW_EN
      pix_m = disp_blank ? 1'b0 : shadow_m[disp_col];
`else
      pix_m = disp_blank ? 1'b0 : snap[disp_row][disp_col];
`endif
      if (pend_m && sb.size() > 0 && sb[sb.size()-1].due == cyc) begin
        t = sb.pop_back();
        t.data = snap[t.addr];
        sb.push_back(t);
        rdata_m = t.data;
        pend_m = 1'b0;
        done_now = 1'b1;
      end else if (!pend_m && !done_last && r_req) begin
        t.addr = r_addr;
        t.due = cyc + LAT;
        t.data = 'x;
        sb.push_back(t);
        pend_m = 1'b1;
      end
      done_last = done_now;
`ifdef BABY_VGA_LINE_SHADOW_EN
      if (line_start)
        shadow_m = (w_en && w_addr == disp_row) ? w_data : snap[disp_row];
`endif
      if (w_en) mem[w_addr] = w_data;
    end
  end

  // monitor
  always @(negedge clk) begin
    chk("r_busy", 32'(r_busy), 32'(pend_m));
    chk("pixel", 32'(pixel), 32'(pix_m));
    chk("r_data_hold", r_data, rdata_m);
    if (r_ready) begin
      if (sb.size() == 0 || sb[0].due != cyc) begin
        chk("r_ready_unexpected", 32'(r_ready), 32'd0);
      end else begin
        chk("read_data", r_data, sb[0].data);
        void'(sb.pop_front());
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("r_ready_missing", 32'(r_ready), 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic drive(input bit we, input logic [3:0] wa,
                       input logic [31:0] wd, input bit rq,
                       input logic [3:0] ra, input bit ls,
                       input logic [3:0] row, input logic [4:0] col,
                       input bit blank);
    w_en = we;
    w_addr = wa;
    w_data = wd;
    r_req = rq;
    r_addr = ra;
    line_start = ls;
    disp_row = row;
    disp_col = col;
    disp_blank = blank;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    w_en = 0; w_addr = 0; w_data = 0;
    r_req = 0; r_addr = 0;
    line_start = 0; disp_row = 0; disp_col = 0; disp_blank = 1;
    repeat (2) @(negedge clk);
    chk("reset_r_data", r_data, 32'd0);
    chk("reset_pixel", 32'(pixel), 32'd0);
    rst_n = 1'b1;

    drive(1, 3, 32'hA5A5_0F0F, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 3, 0, 0, 0, 1);
    idle(1);
    drive(0, 0, 0, 1, 3, 0, 0, 0, 1);
    idle(10);
    chk("plan_read_a5a5", r_data, 32'hA5A5_0F0F);

    drive(1, 5, 32'h0000_0001, 0, 0, 0, 5, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 5, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 0, 0);
    chk("plan_pix_col0", 32'(pixel), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 5, 1, 0);
    chk("plan_pix_col1", 32'(pixel), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 5, 0, 1);
    chk("plan_pix_blank", 32'(pixel), 32'd0);

    drive(1, 5, 32'hFFFF_FFFF, 0, 0, 0, 5, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 5, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 1, 0);
    chk("plan_pix_newline", 32'(pixel), 32'd1);

    drive(1, 7, 32'h8000_0000, 0, 0, 1, 7, 31, 0);
    drive(0, 0, 0, 0, 0, 0, 7, 31, 0);
    chk("plan_pix_bypass", 32'(pixel), 32'd1);

    drive(0, 0, 0, 1, 3, 0, 0, 0, 1);
    idle(3);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(12);
    chk("abort_r_busy", 32'(r_busy), 32'd0);
    chk("abort_r_data", r_data, 32'd0);
    for (int a = 0; a < 16; a++) begin
      drive(0, 0, 0, 1, 4'(a), 0, 0, 0, 1);
      idle(LAT + 2);
    end

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 2) == 0, 4'($urandom), $urandom,
            $urandom_range(0, 3) == 0, 4'($urandom),
            $urandom_range(0, 7) == 0, 4'($urandom), 5'($urandom),
            $urandom_range(0, 3) == 0);
    end
    rst_n = 1'b1;
    idle(LAT + 4);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
